// File: rtl/drive_mode_arbiter.sv
// Power/mode controller: sequences power from a held button and shares one
// motion-command path among the manual, semi-auto and auto blocks.
module drive_mode_arbiter #(
  parameter int unsigned HOLD_ON     = 100_000_000,
  parameter int unsigned HOLD_OFF    = 300_000_000,
  parameter int unsigned DEAD_CYCLES = 10_000_000,
  parameter int unsigned IDLE_CYCLES = 1_000_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power_btn,
  input  logic [1:0] mode_sel,
  input  logic [3:0] man_cmd,
  input  logic       man_fault,
  input  logic [3:0] semi_cmd,
  input  logic [3:0] auto_cmd,
  output logic [3:0] motor_cmd,
  output logic       power_on,
  output logic [1:0] active_mode,
  output logic       sub_rst,
  output logic [2:0] state
);
  typedef enum logic [2:0] {
    ST_OFF    = 3'b001,
    ST_RUN    = 3'b010,
    ST_SWITCH = 3'b100
  } state_t;

  localparam logic [31:0] ON_LAST   = 32'(HOLD_ON - 1);
  localparam logic [31:0] OFF_LAST  = 32'(HOLD_OFF - 1);
  localparam logic [31:0] DEAD_LAST = 32'(DEAD_CYCLES - 1);
  localparam logic [31:0] IDLE_LAST = 32'(IDLE_CYCLES - 1);

  state_t      state_reg;
  logic [31:0] hold_cnt;
  logic [31:0] dead_cnt;
  logic [31:0] idle_cnt;
  logic        armed;
  logic [3:0]  motor_reg;
  logic [1:0]  mode_reg;
  logic        power_reg;
  logic        sub_rst_reg;

  logic [1:0]  req_mode;
  logic [3:0]  sel_cmd;
  logic        pressing;
  logic        moving;
  logic        hold_off_hit;
  logic        go_off;
  logic [31:0] hold_step;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  assign req_mode = (mode_sel == 2'b11) ? 2'b00 : mode_sel;

  always_comb begin
    sel_cmd = man_cmd;
    case (mode_reg)
      2'b01:   sel_cmd = semi_cmd;
      2'b10:   sel_cmd = auto_cmd;
      default: sel_cmd = man_cmd;
    endcase
  end

  // Only forward/back count as motion; turning in place still counts as idle.
  assign moving       = sel_cmd[1:0] != 2'b00;
  assign pressing     = power_btn && armed;
  assign hold_step    = pressing ? sat_inc(hold_cnt) : 32'd0;
  assign hold_off_hit = pressing && (hold_cnt == OFF_LAST);

  always_comb begin
    go_off = 1'b0;
    case (state_reg)
      ST_OFF:    go_off = 1'b0;
      ST_RUN:    go_off = (man_fault && mode_reg == 2'b00) || hold_off_hit ||
                          (!moving && idle_cnt == IDLE_LAST);
      ST_SWITCH: go_off = hold_off_hit;
      default:   go_off = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_OFF;
      hold_cnt    <= 32'd0;
      dead_cnt    <= 32'd0;
      idle_cnt    <= 32'd0;
      armed       <= 1'b0;
      motor_reg   <= 4'd0;
      mode_reg    <= 2'b00;
      power_reg   <= 1'b0;
      sub_rst_reg <= 1'b1;
    end else begin
      if (!power_btn) armed <= 1'b1;
      if (go_off) begin
        // active_mode deliberately keeps its last value across power-off
        state_reg   <= ST_OFF;
        power_reg   <= 1'b0;
        sub_rst_reg <= 1'b1;
        motor_reg   <= 4'd0;
        hold_cnt    <= 32'd0;
        dead_cnt    <= 32'd0;
        idle_cnt    <= 32'd0;
        armed       <= 1'b0;
      end else begin
        case (state_reg)
          ST_OFF: begin
            motor_reg <= 4'd0;
            if (pressing && hold_cnt == ON_LAST) begin
              state_reg   <= ST_RUN;
              power_reg   <= 1'b1;
              sub_rst_reg <= 1'b0;
              mode_reg    <= req_mode;
              hold_cnt    <= 32'd0;
              dead_cnt    <= 32'd0;
              idle_cnt    <= 32'd0;
              armed       <= 1'b0;
            end else begin
              hold_cnt <= hold_step;
            end
          end
          ST_RUN: begin
            hold_cnt <= hold_step;
            if (req_mode != mode_reg && !moving) begin
              state_reg   <= ST_SWITCH;
              sub_rst_reg <= 1'b1;
              motor_reg   <= 4'd0;
              dead_cnt    <= 32'd0;
              idle_cnt    <= 32'd0;
            end else begin
              motor_reg <= sel_cmd;
              idle_cnt  <= moving ? 32'd0 : sat_inc(idle_cnt);
            end
          end
          default: begin
            // Switching: the hold-off count keeps running through the dead time.
            hold_cnt  <= hold_step;
            motor_reg <= 4'd0;
            idle_cnt  <= 32'd0;
            if (dead_cnt == DEAD_LAST) begin
              state_reg   <= ST_RUN;
              sub_rst_reg <= 1'b0;
              mode_reg    <= req_mode;
              dead_cnt    <= 32'd0;
            end else begin
              dead_cnt <= sat_inc(dead_cnt);
            end
          end
        endcase
      end
    end
  end

  assign motor_cmd   = motor_reg;
  assign power_on    = power_reg;
  assign active_mode = mode_reg;
  assign sub_rst     = sub_rst_reg;
  assign state       = state_reg;
endmodule

// File: tb/tb_drive_mode_arbiter.sv
// Bench for drive_mode_arbiter: directed scenarios with literal expectations,
// then randomized stimulus checked every cycle against a behavioural model.
module tb_drive_mode_arbiter;
  localparam int HOLD_ON = 4;
  localparam int HOLD_OFF = 6;
  localparam int DEAD = 3;
  localparam int IDLE = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       power_btn = 1'b0;
  logic [1:0] mode_sel = 2'b00;
  logic [3:0] man_cmd = 4'd0;
  logic       man_fault = 1'b0;
  logic [3:0] semi_cmd = 4'd0;
  logic [3:0] auto_cmd = 4'd0;
  logic [3:0] motor_cmd;
  logic       power_on;
  logic [1:0] active_mode;
  logic       sub_rst;
  logic [2:0] state;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  drive_mode_arbiter #(
    .HOLD_ON(HOLD_ON), .HOLD_OFF(HOLD_OFF), .DEAD_CYCLES(DEAD), .IDLE_CYCLES(IDLE)
  ) dut (
    .clk(clk), .rst(rst), .power_btn(power_btn), .mode_sel(mode_sel),
    .man_cmd(man_cmd), .man_fault(man_fault), .semi_cmd(semi_cmd),
    .auto_cmd(auto_cmd), .motor_cmd(motor_cmd), .power_on(power_on),
    .active_mode(active_mode), .sub_rst(sub_rst), .state(state)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase 0=off, 1=run, 2=switching; press/idle/dead are
  // lengths of the current streaks measured in samples.
  int m_phase, m_press, m_idle, m_dead, m_mode;
  bit m_armed;
  logic [3:0] m_cmd;
  int req, press_now, idle_now;
  logic [3:0] cur;
  bit motion, drop;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_phase = 0; m_press = 0; m_idle = 0; m_dead = 0; m_mode = 0;
        m_armed = 0; m_cmd = 4'd0;
      end else begin
        req = (mode_sel == 2'd3) ? 0 : int'(mode_sel);
        cur = (m_mode == 1) ? semi_cmd : (m_mode == 2) ? auto_cmd : man_cmd;
        motion = cur[1:0] != 2'b00;
        press_now = (power_btn && m_armed) ? m_press + 1 : 0;
        idle_now = motion ? 0 : m_idle + 1;
        if (!power_btn) m_armed = 1;
        drop = 0;
        if (m_phase == 1)
          drop = (man_fault && m_mode == 0) || press_now >= HOLD_OFF || idle_now >= IDLE;
        else if (m_phase == 2)
          drop = press_now >= HOLD_OFF;
        if (drop) begin
          m_phase = 0; m_cmd = 4'd0; m_press = 0; m_idle = 0; m_dead = 0; m_armed = 0;
        end else if (m_phase == 0) begin
          m_cmd = 4'd0;
          if (press_now >= HOLD_ON) begin
            m_phase = 1; m_mode = req; m_press = 0; m_idle = 0; m_dead = 0; m_armed = 0;
          end else begin
            m_press = press_now;
          end
        end else if (m_phase == 1) begin
          m_press = press_now;
          if (req != m_mode && !motion) begin
            m_phase = 2; m_cmd = 4'd0; m_dead = 0; m_idle = 0;
          end else begin
            m_cmd = cur; m_idle = idle_now;
          end
        end else begin
          m_press = press_now;
          m_cmd = 4'd0;
          m_idle = 0;
          m_dead = m_dead + 1;
          if (m_dead == DEAD) begin
            m_phase = 1; m_mode = req; m_dead = 0;
          end
        end
      end
    end
  end

  logic [11:0] got, want;
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        got  = {state, power_on, sub_rst, active_mode, motor_cmd};
        want = {3'b001 << m_phase, m_phase != 0, m_phase != 1, 2'(m_mode), m_cmd};
        total++;
        if (got !== want) begin
          bad++;
          $display("FAIL model t=%0t {state,pwr,srst,mode,cmd} got=%b want=%b", $time, got, want);
        end
      end
    end
  end

  task automatic expect_val(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic power_up(input logic [1:0] m);
    mode_sel = m;
    power_btn = 1'b0; tick(1);
    power_btn = 1'b1; tick(HOLD_ON);
    power_btn = 1'b0;
  endtask

  initial begin
    tick(2);
    chk_en = 1'b1;
    rst = 1'b0;
    tick(1);
    expect_val("reset_state", 8'(state), 8'h01);
    expect_val("reset_power", 8'(power_on), 8'h00);
    expect_val("reset_motor", 8'(motor_cmd), 8'h00);
    expect_val("reset_subrst", 8'(sub_rst), 8'h01);
    $display("scenario: reset checked");

    mode_sel = 2'b01;
    power_btn = 1'b1; tick(3);
    power_btn = 1'b0; tick(1);
    expect_val("short_press_state", 8'(state), 8'h01);
    power_btn = 1'b1; tick(HOLD_ON);
    expect_val("pon_state", 8'(state), 8'h02);
    expect_val("pon_power", 8'(power_on), 8'h01);
    expect_val("pon_mode", 8'(active_mode), 8'h01);
    expect_val("pon_subrst", 8'(sub_rst), 8'h00);
    semi_cmd = 4'b0001; tick(1);
    expect_val("semi_pass", 8'(motor_cmd), 8'h01);
    tick(8);
    expect_val("no_instant_off", 8'(state), 8'h02);
    power_btn = 1'b0; tick(1);
    power_btn = 1'b1; tick(HOLD_OFF - 1);
    expect_val("poff_early", 8'(state), 8'h02);
    tick(1);
    expect_val("poff_state", 8'(state), 8'h01);
    expect_val("poff_motor", 8'(motor_cmd), 8'h00);
    $display("scenario: power on/off sequence done");

    man_cmd = 4'd0;
    power_up(2'b00);
    expect_val("sw_run_mode", 8'(active_mode), 8'h00);
    man_cmd = 4'b0001; mode_sel = 2'b10; auto_cmd = 4'b1010; tick(3);
    expect_val("sw_ignored_moving", 8'(state), 8'h02);
    expect_val("sw_man_pass", 8'(motor_cmd), 8'h01);
    man_cmd = 4'b0100;
    for (int i = 0; i < DEAD; i++) begin
      tick(1);
      expect_val("sw_dead_state", 8'(state), 8'h04);
      expect_val("sw_dead_motor", 8'(motor_cmd), 8'h00);
      expect_val("sw_dead_subrst", 8'(sub_rst), 8'h01);
    end
    tick(1);
    expect_val("sw_back_run", 8'(state), 8'h02);
    expect_val("sw_new_mode", 8'(active_mode), 8'h02);
    expect_val("sw_first_cycle_zero", 8'(motor_cmd), 8'h00);
    tick(1);
    expect_val("sw_auto_pass", 8'(motor_cmd), 8'h0a);
    $display("scenario: mode switch done");

    auto_cmd = 4'b0100; tick(14);
    expect_val("idle_early", 8'(state), 8'h02);
    auto_cmd = 4'b0001; tick(1);
    auto_cmd = 4'b0100; tick(IDLE - 1);
    expect_val("idle_restarted", 8'(state), 8'h02);
    tick(1);
    expect_val("idle_off", 8'(state), 8'h01);
    $display("scenario: idle timeout done");

    power_up(2'b00);
    man_fault = 1'b1; mode_sel = 2'b01; tick(1);
    man_fault = 1'b0;
    expect_val("fault_off", 8'(state), 8'h01);
    semi_cmd = 4'b0001;
    power_up(2'b01);
    man_fault = 1'b1; tick(3);
    man_fault = 1'b0;
    expect_val("fault_ignored_semi", 8'(state), 8'h02);
    $display("scenario: fault priority done");

    semi_cmd = 4'b0000; mode_sel = 2'b10; tick(1);
    expect_val("rst_pre_switch", 8'(state), 8'h04);
    rst = 1'b1; tick(1);
    rst = 1'b0;
    expect_val("rst_state", 8'(state), 8'h01);
    expect_val("rst_motor", 8'(motor_cmd), 8'h00);
    expect_val("rst_power", 8'(power_on), 8'h00);
    expect_val("rst_subrst", 8'(sub_rst), 8'h01);
    $display("scenario: reset mid-switch done");

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) power_btn = ~power_btn;
      if ($urandom_range(15) == 0) mode_sel = 2'($urandom_range(3));
      if ($urandom_range(5) == 0) man_cmd = 4'($urandom_range(15));
      if ($urandom_range(5) == 0) semi_cmd = 4'($urandom_range(15));
      if ($urandom_range(5) == 0) auto_cmd = 4'($urandom_range(15));
      man_fault = ($urandom_range(31) == 0);
      rst = ($urandom_range(399) == 0);
      tick(1);
    end
    rst = 1'b0;
    tick(1);
    $display("scenario: random phase done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
